// File: rtl/pulse_width_receive.sv
// pulse_width_receive: decodes the pulse-width audio line back into 8-bit samples.
// A frame is a sync mark (long low, long high) followed by 8 data bits, MSB first.
// Each bit is a short low followed by a short high ("0") or a long high ("1").
// Optional build macro RX_ERR_COUNT_EN adds a saturating 16-bit error counter output.
module pulse_width_receive #(
    parameter int SYNC_LOW  = 400,
    parameter int SYNC_HIGH = 600,
    parameter int BIT_LOW   = 200,
    parameter int ZERO_HIGH = 200,
    parameter int ONE_HIGH  = 600,
    parameter int TOL       = 50
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        signal_in,
    output logic [7:0]  audio_out,
    output logic        audio_valid_out,
    output logic        error_out
`ifdef RX_ERR_COUNT_EN
    ,
    output logic [15:0] err_count_out
`endif
);

    localparam int RUN_MAX = SYNC_LOW + SYNC_HIGH;
    localparam int CW      = $clog2(RUN_MAX + 1);
    localparam logic [CW-1:0] RUN_MAX_C = CW'(RUN_MAX);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        SYNC_HI = 2'd1,
        BIT_LO  = 2'd2,
        BIT_HI  = 2'd3
    } state_t;

    // True when a completed run length lies within +/-TOL of a nominal width.
    function automatic logic in_window(input logic [CW-1:0] len, input int nominal);
        int l;
        l = int'(len);
        return (l >= nominal - TOL) && (l <= nominal + TOL);
    endfunction

    logic          meta_r;
    logic          sig_s_r;
    logic          sig_d_r;
    logic [CW-1:0] run_cnt_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [2:0]    bit_cnt_r;
    logic [2:0]    bit_cnt_nxt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_nxt_s;
    logic [7:0]    audio_r;
    logic [7:0]    audio_nxt_s;
    logic          valid_r;
    logic          valid_nxt_s;
    logic          error_r;
    logic          error_nxt_s;

    logic edge_s;
    logic rise_s;
    logic fall_s;
    logic syncl_s;
    logic synch_s;
    logic bitl_s;
    logic w0_s;
    logic w1_s;
    logic sync_hi_to_s;
    logic bit_lo_to_s;
    logic bit_hi_to_s;

    assign edge_s = sig_s_r ^ sig_d_r;
    assign rise_s = sig_s_r & ~sig_d_r;
    assign fall_s = ~sig_s_r & sig_d_r;

    // On an edge cycle run_cnt_r holds the length of the run that just ended.
    assign syncl_s = int'(run_cnt_r) >= (SYNC_LOW - TOL);
    assign synch_s = in_window(run_cnt_r, SYNC_HIGH);
    assign bitl_s  = in_window(run_cnt_r, BIT_LOW);
    assign w0_s    = in_window(run_cnt_r, ZERO_HIGH);
    assign w1_s    = in_window(run_cnt_r, ONE_HIGH);

    // Timeouts look at the count before this cycle's increment.
    assign sync_hi_to_s = int'(run_cnt_r) > (SYNC_HIGH + TOL);
    assign bit_lo_to_s  = int'(run_cnt_r) > (SYNC_LOW - TOL);
    assign bit_hi_to_s  = int'(run_cnt_r) > (ONE_HIGH + TOL);

    // Two-flop synchronizer for the asynchronous line plus one delayed copy for edge detection.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            meta_r  <= 1'b0;
            sig_s_r <= 1'b0;
            sig_d_r <= 1'b0;
        end else begin
            meta_r  <= signal_in;
            sig_s_r <= meta_r;
            sig_d_r <= sig_s_r;
        end
    end

    // Run-length counter: restarts at 1 on every edge, otherwise counts up and saturates.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            run_cnt_r <= '0;
        end else if (edge_s) begin
            run_cnt_r <= CW'(1);
        end else if (run_cnt_r != RUN_MAX_C) begin
            run_cnt_r <= run_cnt_r + CW'(1);
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, shift register and strobe decisions for one measured run.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        audio_nxt_s   = audio_r;
        valid_nxt_s   = 1'b0;
        error_nxt_s   = 1'b0;
        case (state_r)
            HUNT: begin
                if (rise_s && syncl_s) begin
                    state_nxt_s = SYNC_HI;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            SYNC_HI: begin
                if (fall_s) begin
                    if (synch_s) begin
                        state_nxt_s   = BIT_LO;
                        bit_cnt_nxt_s = 3'd0;
                        shift_nxt_s   = 8'h00;
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end else if (sync_hi_to_s) begin
                    state_nxt_s = HUNT;
                end else begin
                    state_nxt_s = SYNC_HI;
                end
            end
            BIT_LO: begin
                if (rise_s) begin
                    if (bitl_s) begin
                        state_nxt_s = BIT_HI;
                    end else if (syncl_s) begin
                        // Looks like a fresh sync low: flag the broken frame but relock at once.
                        error_nxt_s = 1'b1;
                        state_nxt_s = SYNC_HI;
                    end else begin
                        error_nxt_s = 1'b1;
                        state_nxt_s = HUNT;
                    end
                end else if (bit_lo_to_s) begin
                    error_nxt_s = 1'b1;
                    state_nxt_s = HUNT;
                end else begin
                    state_nxt_s = BIT_LO;
                end
            end
            BIT_HI: begin
                if (fall_s) begin
                    if (w0_s || w1_s) begin
                        shift_nxt_s   = {shift_r[6:0], w1_s};
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            audio_nxt_s = {shift_r[6:0], w1_s};
                            valid_nxt_s = 1'b1;
                            state_nxt_s = HUNT;
                        end else begin
                            state_nxt_s = BIT_LO;
                        end
                    end else begin
                        error_nxt_s = 1'b1;
                        state_nxt_s = HUNT;
                    end
                end else if (bit_hi_to_s) begin
                    error_nxt_s = 1'b1;
                    state_nxt_s = HUNT;
                end else begin
                    state_nxt_s = BIT_HI;
                end
            end
            default: begin
                state_nxt_s = HUNT;
            end
        endcase
    end

    // Data path and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            audio_r   <= 8'h00;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            audio_r   <= audio_nxt_s;
            valid_r   <= valid_nxt_s;
            error_r   <= error_nxt_s;
        end
    end

    assign audio_out       = audio_r;
    assign audio_valid_out = valid_r;
    assign error_out       = error_r;

`ifdef RX_ERR_COUNT_EN
    logic [15:0] err_count_r;

    // Saturating count of error strobes since the last reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_count_r <= 16'h0000;
        end else if (error_r && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'h0001;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count_out = err_count_r;
`endif

endmodule

// File: tb/tb_pulse_width_receive.sv
// Directed bench for pulse_width_receive: drives hand-built pulse-width frames and
// compares decoded samples, strobes and error pulses against hand-computed values.
module tb_pulse_width_receive;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        signal_in;
    logic [7:0]  audio_out;
    logic        audio_valid_out;
    logic        error_out;
`ifdef RX_ERR_COUNT_EN
    logic [15:0] err_count_out;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state (written only by the monitor process).
    logic [7:0] rx_mem [0:63];
    int rx_wr     = 0;
    int err_seen  = 0;
    int both_seen = 0;

    // Bench-side read pointers.
    int rx_rd    = 0;
    int err_base = 0;

    pulse_width_receive dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .signal_in       (signal_in),
        .audio_out       (audio_out),
        .audio_valid_out (audio_valid_out),
        .error_out       (error_out)
`ifdef RX_ERR_COUNT_EN
        ,
        .err_count_out   (err_count_out)
`endif
    );

    always #5 clk = ~clk;

    // Record strobes on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (audio_valid_out) begin
            rx_mem[rx_wr % 64] <= audio_out;
            rx_wr <= rx_wr + 1;
        end
        if (error_out) begin
            err_seen <= err_seen + 1;
        end
        if (audio_valid_out && error_out) begin
            both_seen <= both_seen + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold the line at a level for n clock cycles (called at a falling edge).
    task automatic hold(input logic v, input int n);
        signal_in = v;
        repeat (n) @(negedge clk);
    endtask

    // One frame: sync then nbits bits MSB first; optional oversized/overridden widths,
    // one bit with a forced high width, and a one-cycle reset in a bit's low phase.
    task automatic send_frame(input logic [7:0] d, input int off_sync, input int off_bits,
                              input int sync_high_w, input int nbits, input int bad_bit,
                              input int bad_high, input int rst_at);
        int sh;
        int bl;
        int hw;
        int i;
        sh = (sync_high_w > 0) ? sync_high_w : 600 + off_sync;
        bl = 200 + off_bits;
        hold(1'b0, 400 + off_sync);
        hold(1'b1, sh);
        for (int k = 0; k < nbits; k++) begin
            i = 7 - k;
            if (k == rst_at) begin
                signal_in = 1'b0;
                rst_in = 1'b1;
                @(negedge clk);
                rst_in = 1'b0;
                check_eq("reset audio_out", {24'd0, audio_out}, 32'd0);
                check_eq("reset valid", {31'd0, audio_valid_out}, 32'd0);
                check_eq("reset error", {31'd0, error_out}, 32'd0);
                hold(1'b0, bl - 1);
            end else begin
                hold(1'b0, bl);
            end
            if (i == bad_bit) begin
                hw = bad_high;
            end else begin
                hw = d[i] ? (600 + off_bits) : (200 + off_bits);
            end
            hold(1'b1, hw);
        end
        signal_in = 1'b0;
    endtask

    // Transmit-stage model at a 12 kHz sample rate: one frame per 8192 clocks.
    task automatic tx_sample(input logic [7:0] d);
        int len;
        len = 1000;
        for (int j = 0; j < 8; j++) begin
            len += d[j] ? 800 : 400;
        end
        send_frame(d, 0, 0, 0, 8, -1, 0, -1);
        hold(1'b0, 8192 - len);
    endtask

    // Compare strobes and errors seen since the previous call.
    task automatic expect_rx(input string tag, input int n_exp, input int err_exp,
                             input logic [7:0] v0, input logic [7:0] v1);
        hold(1'b0, 30);
        check_eq({tag, " strobes"}, rx_wr - rx_rd, n_exp);
        check_eq({tag, " errors"}, err_seen - err_base, err_exp);
        for (int j = 0; j < n_exp && rx_rd < rx_wr; j++) begin
            check_eq({tag, " value"}, {24'd0, rx_mem[rx_rd % 64]}, {24'd0, (j == 0) ? v0 : v1});
            rx_rd++;
        end
        rx_rd    = rx_wr;
        err_base = err_seen;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        signal_in = 1'b0;
        rst_in    = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset audio", {24'd0, audio_out}, 32'd0);
        check_eq("reset valid", {31'd0, audio_valid_out}, 32'd0);
        check_eq("reset error", {31'd0, error_out}, 32'd0);
        rst_in = 1'b0;
        hold(1'b0, 20);

        // Nominal frame 0xA5 with strobe latency after the final falling level.
        send_frame(8'hA5, 0, 0, 0, 8, -1, 0, -1);
        k = 0;
        while (!audio_valid_out && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("latency", k, 3);
        check_eq("a5 audio_out", {24'd0, audio_out}, 32'h0000_00A5);
        expect_rx("a5", 1, 0, 8'hA5, 8'h00);
        check_eq("a5 audio held", {24'd0, audio_out}, 32'h0000_00A5);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 0, 0, 0, 8, -1, 0, -1);
        send_frame(8'hFF, 0, 0, 0, 8, -1, 0, -1);
        expect_rx("b2b", 2, 0, 8'h00, 8'hFF);

        // Loopback from the 12 kHz transmit model.
        tx_sample(8'h12);
        tx_sample(8'hE7);
        expect_rx("loop", 2, 0, 8'h12, 8'hE7);

        // Every width at the window edges.
        send_frame(8'h3C, 50, 50, 0, 8, -1, 0, -1);
        expect_rx("plus_tol", 1, 0, 8'h3C, 8'h00);
        send_frame(8'h3C, -50, -50, 0, 8, -1, 0, -1);
        expect_rx("minus_tol", 1, 0, 8'h3C, 8'h00);

        // Data widths one past the window: error on the first bit low.
        send_frame(8'h3C, 0, 51, 0, 1, -1, 0, -1);
        expect_rx("plus_tol1", 0, 1, 8'h00, 8'h00);
        send_frame(8'h3C, 0, -51, 0, 1, -1, 0, -1);
        expect_rx("minus_tol1", 0, 1, 8'h00, 8'h00);

        // Sync high one past the window: silently back to hunting.
        send_frame(8'h3C, 0, 0, 651, 2, -1, 0, -1);
        expect_rx("sync651", 0, 0, 8'h00, 8'h00);

        // Bit 3 high of 400 matches neither symbol.
        send_frame(8'h00, 0, 0, 0, 8, 3, 400, -1);
        expect_rx("bad_bit3", 0, 1, 8'h00, 8'h00);

        // Glitch on idle line and an overlong sync high.
        hold(1'b0, 400);
        hold(1'b1, 50);
        expect_rx("glitch", 0, 0, 8'h00, 8'h00);
        send_frame(8'h3C, 0, 0, 700, 1, -1, 0, -1);
        expect_rx("sync700", 0, 0, 8'h00, 8'h00);

        send_frame(8'h81, 0, 0, 0, 8, -1, 0, -1);
        expect_rx("recover81", 1, 0, 8'h81, 8'h00);

        // Reset pulse after bit 4 abandons the frame.
        send_frame(8'hC3, 0, 0, 0, 8, -1, 0, 5);
        expect_rx("reset_frame", 0, 0, 8'h00, 8'h00);
        check_eq("post reset audio", {24'd0, audio_out}, 32'd0);

        send_frame(8'h5A, 0, 0, 0, 8, -1, 0, -1);
        expect_rx("after_reset5a", 1, 0, 8'h5A, 8'h00);

`ifdef RX_ERR_COUNT_EN
        for (int f = 0; f < 3; f++) begin
            send_frame(8'h3C, 0, -51, 0, 1, -1, 0, -1);
            hold(1'b0, 30);
        end
        expect_rx("err_cnt_frames", 0, 3, 8'h00, 8'h00);
        check_eq("err_count_out", {16'd0, err_count_out}, 32'd3);
`endif

        check_eq("valid with error", both_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
